snn_mac_stream: RTL and testbench



---
 rtl/snn_mac_stream_if.sv | 31 +++
 rtl/snn_mac_stream.sv | 152 +++++++++++++++
 tb/tb_snn_mac_stream.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_mac_stream_if.sv
// Stream interface for snn_mac_stream.
// Input side: beats of spike bits plus signed weights, framed by in_last.
// Output side: one saturated result per frame.
// The master modport is the producer/consumer environment; the slave modport is the MAC.
interface snn_mac_stream_if #(
  parameter int LANES     = 5,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES-1:0]              in_spikes;
  logic [LANES*W_WIDTH-1:0]      in_weights;
  logic                          in_last;
  logic signed [ACC_WIDTH-1:0]   bias;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_WIDTH-1:0]   out_sum;
  logic                          out_sat;

  modport master (
    output in_valid, in_spikes, in_weights, in_last, bias, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_spikes, in_weights, in_last, bias, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/snn_mac_stream.sv
// Streaming spike x weight multiply-accumulate.
// Stage 1 registers the exact lane sum of one beat; stage 2 accumulates the
// frame with saturation, adds the bias on the last beat and holds the result
// on a valid/ready output. A stalled output freezes the whole pipeline.
module snn_mac_stream #(
  parameter int LANES     = 5,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  snn_mac_stream_if.slave   bus
);

  localparam int SUM_W = W_WIDTH + $clog2(LANES);
  // Two guard bits cover acc + lane sum and acc + bias without overflow.
  localparam int EXT_W = ACC_WIDTH + 2;

  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [EXT_W-1:0] x);
    if (x > ACC_MAX) return ACC_MAX[ACC_WIDTH-1:0];
    if (x < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
    return x[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] x);
    if (x > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (x < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return x[OUT_WIDTH-1:0];
  endfunction

  logic                         ready_p0;
  logic                         stall;
  logic                         accept;
  logic signed [SUM_W-1:0]      lane_sum;
  logic signed [W_WIDTH-1:0]    lane_w;

  logic                         vld_p1;
  logic                         last_p1;
  logic signed [SUM_W-1:0]      sum_p1;

  logic signed [ACC_WIDTH-1:0]  acc_p2;
  logic                         sticky_p2;
  logic                         vld_p2;
  logic signed [OUT_WIDTH-1:0]  sum_p2;
  logic                         sat_p2;

  logic signed [EXT_W-1:0]      acc_x;
  logic signed [EXT_W-1:0]      sum_x;
  logic signed [EXT_W-1:0]      bias_x;
  logic signed [EXT_W-1:0]      step_x;
  logic signed [ACC_WIDTH-1:0]  step_acc;
  logic signed [EXT_W-1:0]      step_acc_x;
  logic signed [EXT_W-1:0]      biased_x;
  logic signed [ACC_WIDTH-1:0]  biased_acc;
  logic signed [EXT_W-1:0]      biased_acc_x;
  logic signed [OUT_WIDTH-1:0]  result;
  logic signed [ACC_WIDTH-1:0]  result_x;
  logic                         clamp_step;
  logic                         clamp_bias;
  logic                         clamp_out;

  assign stall        = vld_p2 && !bus.out_ready;
  assign bus.in_ready = ready_p0 && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = vld_p2;
  assign bus.out_sum   = sum_p2;
  assign bus.out_sat   = sat_p2;

  // Exact signed sum of the weights whose spike bit is set in this beat.
  always_comb begin
    lane_sum = '0;
    lane_w   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_w = bus.in_weights[i*W_WIDTH +: W_WIDTH];
      if (bus.in_spikes[i]) lane_sum = lane_sum + SUM_W'(lane_w);
    end
  end

  // Saturating accumulate, bias add and output clamp, with a flag per clamp point.
  always_comb begin
    acc_x        = EXT_W'(acc_p2);
    sum_x        = EXT_W'(sum_p1);
    bias_x       = EXT_W'(bus.bias);
    step_x       = acc_x + sum_x;
    step_acc     = sat_acc(step_x);
    step_acc_x   = EXT_W'(step_acc);
    clamp_step   = (step_acc_x != step_x);
    biased_x     = step_acc_x + bias_x;
    biased_acc   = sat_acc(biased_x);
    biased_acc_x = EXT_W'(biased_acc);
    clamp_bias   = (biased_acc_x != biased_x);
    result       = sat_out(biased_acc);
    result_x     = ACC_WIDTH'(result);
    clamp_out    = (result_x != biased_acc);
  end

  // Input ready comes up one cycle after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_p0 <= 1'b0;
    else        ready_p0 <= 1'b1;
  end

  // Stage 1: capture the lane sum of an accepted beat; frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      sum_p1  <= '0;
    end else if (!stall) begin
      vld_p1 <= accept;
      if (accept) begin
        sum_p1  <= lane_sum;
        last_p1 <= bus.in_last;
      end
    end
  end

  // Stage 2: accumulate the frame; on the last beat publish the result and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2    <= '0;
      sticky_p2 <= 1'b0;
      vld_p2    <= 1'b0;
      sum_p2    <= '0;
      sat_p2    <= 1'b0;
    end else if (!stall) begin
      vld_p2 <= 1'b0;
      if (vld_p1 && last_p1) begin
        sum_p2    <= result;
        sat_p2    <= sticky_p2 | clamp_step | clamp_bias | clamp_out;
        vld_p2    <= 1'b1;
        acc_p2    <= '0;
        sticky_p2 <= 1'b0;
      end else if (vld_p1) begin
        acc_p2    <= step_acc;
        sticky_p2 <= sticky_p2 | clamp_step;
      end
    end
  end

endmodule

// File: tb/tb_snn_mac_stream.sv
// Bench for snn_mac_stream: directed frames plus randomized frames, each
// predicted by an integer reference model and checked by a scoreboard monitor.
module tb_snn_mac_stream;
  localparam int LANES     = 5;
  localparam int W_WIDTH   = 8;
  localparam int ACC_WIDTH = 16;
  localparam int OUT_WIDTH = 8;

  typedef struct {
    int sum;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snn_mac_stream_if #(.LANES(LANES), .W_WIDTH(W_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  snn_mac_stream #(.LANES(LANES), .W_WIDTH(W_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // reference model state for the frame being streamed
  longint acc_m     = 0;
  int     sticky_m  = 0;
  int     frame_bias = 0;
  int     rand_ready = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint clampi(input longint v, input int n);
    longint hi, lo;
    hi = (longint'(1) <<< (n - 1)) - 1;
    lo = -(longint'(1) <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint beat_sum(input logic [LANES-1:0] sp, input logic [LANES*W_WIDTH-1:0] wv);
    longint s;
    logic signed [W_WIDTH-1:0] w;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      w = wv[i*W_WIDTH +: W_WIDTH];
      if (sp[i]) s += longint'(w);
    end
    return s;
  endfunction

  // Reference behaviour of one accepted beat, expressed as integer arithmetic.
  task automatic model_beat(input logic [LANES-1:0] sp, input logic [LANES*W_WIDTH-1:0] wv, input bit last);
    longint raw, t1, t2, o;
    int c;
    raw = acc_m + beat_sum(sp, wv);
    t1  = clampi(raw, ACC_WIDTH);
    c   = (t1 != raw);
    if (!last) begin
      acc_m    = t1;
      sticky_m = sticky_m | c;
    end else begin
      t2 = clampi(t1 + frame_bias, ACC_WIDTH);
      c  = c | (t2 != t1 + frame_bias);
      o  = clampi(t2, OUT_WIDTH);
      c  = c | (o != t2);
      exp_q.push_back('{sum: int'(o), sat: sticky_m | c});
      acc_m    = 0;
      sticky_m = 0;
    end
  endtask

  // Present one beat and wait for its acceptance; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [LANES-1:0] sp, input logic [LANES*W_WIDTH-1:0] wv, input bit last);
    int cyc;
    bus.in_valid   = 1'b1;
    bus.in_spikes  = sp;
    bus.in_weights = wv;
    bus.in_last    = last;
    cyc = 0;
    @(negedge clk);
    while (!bus.in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready stuck at 0 for %0d cycles", cyc);
      $fatal(1, "in_ready never asserted");
    end
    @(posedge clk);
    #1;
    model_beat(sp, wv, last);
    if (last) bus.bias = frame_bias[ACC_WIDTH-1:0];
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_uniform(input int nbeats, input logic [LANES-1:0] sp, input int w, input bit end_frame);
    logic signed [W_WIDTH-1:0] wb;
    logic [LANES*W_WIDTH-1:0] wv;
    wb = w[W_WIDTH-1:0];
    wv = {LANES{wb}};
    for (int i = 0; i < nbeats; i++) send_beat(sp, wv, end_frame && (i == nbeats - 1));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready != 0) bus.out_ready = ($urandom_range(0, 9) < 7);
  end

  // Scoreboard monitor: compare every handshake, and check held output stability.
  logic signed [OUT_WIDTH-1:0] held_sum;
  logic                        held_sat;
  bit                          have_hold = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_hold = 0;
    end else if (bus.out_valid) begin
      if (have_hold) begin
        check("hold_sum", int'(bus.out_sum), int'(held_sum));
        check("hold_sat", int'(bus.out_sat), int'(held_sat));
      end
      if (bus.out_ready) begin
        have_hold = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", int'(bus.out_sum), e.sum);
          check("out_sat", int'(bus.out_sat), e.sat);
        end
      end else begin
        have_hold = 1;
        held_sum  = bus.out_sum;
        held_sat  = bus.out_sat;
      end
    end
  end

  initial begin
    logic [63:0] r;
    logic [LANES*W_WIDTH-1:0] wv;
    int nb;
    int cyc;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_spikes  = '0;
    bus.in_weights = '0;
    bus.in_last    = 1'b0;
    bus.bias       = '0;
    bus.out_ready  = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sum", int'(bus.out_sum), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_after_edge", int'(bus.in_ready), 1);

    // 1: 5 beats of 5x3 -> 75, output appears on the edge after the last accept
    frame_bias = 0;
    send_uniform(5, '1, 3, 1);
    check("lat_accept_edge", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_next_edge_valid", int'(bus.out_valid), 1);
    check("lat_next_edge_sum", int'(bus.out_sum), 75);
    drain();

    // 2: output clamp both directions
    send_uniform(5, '1, 127, 1);
    send_uniform(5, '1, -128, 1);
    drain();

    // 3: accumulator clamps at 32767 and holds, result pulled back into range (sticky sat)
    frame_bias = -100;
    send_uniform(60, '1, 127, 0);
    send_uniform(51, '1, -128, 1);
    drain();

    // 4: silent spikes give the bias alone, then back-to-back frames with no bubble
    frame_bias = -5;
    r  = {$urandom(), $urandom()};
    wv = r[LANES*W_WIDTH-1:0];
    send_beat('0, wv, 1);
    drain();
    frame_bias = 0;
    send_uniform(2, 5'b00001, 5, 1);
    send_uniform(1, 5'b01111, 5, 1);
    check("b2b_first_valid", int'(bus.out_valid), 1);
    check("b2b_first_sum", int'(bus.out_sum), 10);
    @(posedge clk);
    #1;
    check("b2b_second_valid", int'(bus.out_valid), 1);
    check("b2b_second_sum", int'(bus.out_sum), 20);
    drain();

    // 5: held output stalls the input while a second frame streams
    bus.out_ready = 1'b0;
    frame_bias = 7;
    fork
      begin
        r  = {$urandom(), $urandom()};
        wv = r[LANES*W_WIDTH-1:0];
        send_beat(5'b10101, wv, 0);
        send_beat(5'b11111, wv, 1);
        send_beat(5'b00011, wv, 0);
        send_beat(5'b11100, wv, 0);
        send_beat(5'b01010, wv, 1);
      end
      begin
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
          @(negedge clk);
          cyc++;
        end
        check("stall_out_valid", int'(bus.out_valid), 1);
        repeat (6) begin
          check("stall_in_ready", int'(bus.in_ready), 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // 6: reset in the middle of a frame discards its partial sum
    frame_bias = 0;
    send_uniform(2, '1, 50, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_sum", int'(bus.out_sum), 0);
    check("midrst_out_sat", int'(bus.out_sat), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    acc_m    = 0;
    sticky_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    r  = {$urandom(), $urandom()};
    wv = r[LANES*W_WIDTH-1:0];
    wv[W_WIDTH-1:0] = 8'd1;
    send_beat(5'b00001, wv, 1);
    @(posedge clk);
    #1;
    check("postrst_sum", int'(bus.out_sum), 1);
    drain();

    // randomized frames with bubbles and random backpressure
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) frame_bias = $urandom_range(0, 400) - 200;
      else                           frame_bias = $urandom_range(0, 65535) - 32768;
      for (int b = 0; b < nb; b++) begin
        r  = {$urandom(), $urandom()};
        wv = r[LANES*W_WIDTH-1:0];
        send_beat(r[63:59], wv, b == nb - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
